// File: rtl/mem_request_scheduler_pkg.sv
// Shared types for the memory request scheduler: address/size types, FSM
// state encoding and the boundary-aware request length helper.
package libstf;

   localparam int VADDR_BITS = 48;
   localparam int SIZE_BITS  = 32;

   typedef logic [VADDR_BITS-1:0] vaddress_t;
   typedef logic [SIZE_BITS-1:0]  alloc_size_t;

   typedef enum logic {
      SCHED_ARB   = 1'b0,
      SCHED_ISSUE = 1'b1
   } sched_state_e;

   // Largest request that starts at vaddr without crossing a max_transfer
   // boundary, capped by the bytes still owed to the buffer.
   function automatic alloc_size_t chunk_len(input vaddress_t   vaddr,
                                             input alloc_size_t remaining,
                                             input int unsigned max_transfer);
      alloc_size_t offset;
      alloc_size_t space;
      offset = alloc_size_t'(vaddr & vaddress_t'(max_transfer - 1));
      space  = alloc_size_t'(max_transfer) - offset;
      return (remaining < space) ? remaining : space;
   endfunction

endpackage

// File: rtl/mem_request_scheduler_if.sv
// Descriptor and request buses of the scheduler. Both sides use valid/ready:
// a transfer happens on a rising edge where valid and ready are both 1, and
// the sender holds valid and its payload stable until that edge.
interface mem_request_scheduler_if #(
   parameter int NUM_STREAMS  = 4,
   parameter int MAX_TRANSFER = 4096
) ();
   import libstf::*;

   localparam int LEN_W = $clog2(MAX_TRANSFER) + 1;
   localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   logic [NUM_STREAMS-1:0]              buf_valid;
   logic [NUM_STREAMS-1:0]              buf_ready;
   vaddress_t   [NUM_STREAMS-1:0]       buf_vaddr;
   alloc_size_t [NUM_STREAMS-1:0]       buf_size;

   logic                                req_valid;
   logic                                req_ready;
   vaddress_t                           req_vaddr;
   logic [LEN_W-1:0]                    req_len;
   logic [IDX_W-1:0]                    req_stream;
   logic                                req_last;

   logic                                idle;

   modport master (
      output buf_valid, buf_vaddr, buf_size, req_ready,
      input  buf_ready, req_valid, req_vaddr, req_len, req_stream, req_last, idle
   );

   modport slave (
      input  buf_valid, buf_vaddr, buf_size, req_ready,
      output buf_ready, req_valid, req_vaddr, req_len, req_stream, req_last, idle
   );

endinterface

// File: rtl/mem_request_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after i_ptr,
// wrapping past the top index back to 0.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_grant,
   output logic             o_grant_valid
);

   int w_best_dist;
   int w_dist;

   // Distance from the pointer in wrap-around order; the nearest requester wins.
   always_comb begin
      o_grant       = '0;
      o_grant_valid = 1'b0;
      w_best_dist   = N;
      w_dist        = 0;
      for (int i = 0; i < N; i++) begin
         w_dist = (i + N - int'(i_ptr)) % N;
         if (i_req[i] && (w_dist < w_best_dist)) begin
            w_best_dist   = w_dist;
            o_grant       = IDX_W'(i);
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_request_scheduler.sv
// Splits per-stream buffer descriptors into MAX_TRANSFER-aligned requests and
// issues them one at a time, round-robin across streams.
module mem_request_scheduler
   import libstf::*;
#(
   parameter int NUM_STREAMS  = 4,
   parameter int MAX_TRANSFER = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   mem_request_scheduler_if.slave  bus,
   output sched_state_e            o_dbg_state
);

   localparam int LEN_W = $clog2(MAX_TRANSFER) + 1;
   localparam int IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   vaddress_t              r_vaddr     [NUM_STREAMS];
   alloc_size_t            r_remaining [NUM_STREAMS];
   logic [NUM_STREAMS-1:0] r_full;
   logic [NUM_STREAMS-1:0] r_buf_ready;

   sched_state_e           r_state;
   logic [IDX_W-1:0]       r_ptr;
   logic                   r_req_valid;
   vaddress_t              r_req_vaddr;
   logic [LEN_W-1:0]       r_req_len;
   logic [IDX_W-1:0]       r_req_stream;
   logic                   r_req_last;

   logic [NUM_STREAMS-1:0] w_hs;
   logic [NUM_STREAMS-1:0] w_load;
   logic [NUM_STREAMS-1:0] w_full_next;
   logic                   w_accept;
   logic [IDX_W-1:0]       w_grant;
   logic                   w_grant_valid;
   alloc_size_t            w_len;
   logic [IDX_W-1:0]       w_ptr_next;

   assign w_hs     = bus.buf_valid & r_buf_ready;
   assign w_accept = (r_state == SCHED_ISSUE) && bus.req_ready;

   rr_arbiter #(
      .N     (NUM_STREAMS),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .i_req         (r_full),
      .i_ptr         (r_ptr),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   assign w_len      = chunk_len(r_vaddr[w_grant], r_remaining[w_grant], MAX_TRANSFER);
   assign w_ptr_next = (r_req_stream == IDX_W'(NUM_STREAMS - 1)) ? '0
                                                                 : r_req_stream + IDX_W'(1);

   // Zero-size descriptors complete the handshake but never occupy the slot.
   always_comb begin
      w_load      = '0;
      w_full_next = r_full;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         w_load[i] = w_hs[i] && (bus.buf_size[i] != '0);
         if (w_load[i]) begin
            w_full_next[i] = 1'b1;
         end else if (w_accept && r_req_last && (r_req_stream == IDX_W'(i))) begin
            w_full_next[i] = 1'b0;
         end
      end
   end

   // Ready also drops for the cycle after any handshake, so a discarded
   // descriptor still sees one ready-low cycle before the slot reopens.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_full      <= '0;
         r_buf_ready <= '0;
         for (int i = 0; i < NUM_STREAMS; i++) begin
            r_vaddr[i]     <= '0;
            r_remaining[i] <= '0;
         end
      end else begin
         r_full      <= w_full_next;
         r_buf_ready <= ~(w_full_next | w_hs);
         for (int i = 0; i < NUM_STREAMS; i++) begin
            if (w_load[i]) begin
               r_vaddr[i]     <= bus.buf_vaddr[i];
               r_remaining[i] <= bus.buf_size[i];
            end else if (w_accept && (r_req_stream == IDX_W'(i))) begin
               r_vaddr[i]     <= r_vaddr[i] + vaddress_t'(r_req_len);
               r_remaining[i] <= r_remaining[i] - alloc_size_t'(r_req_len);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= SCHED_ARB;
         r_ptr        <= '0;
         r_req_valid  <= 1'b0;
         r_req_vaddr  <= '0;
         r_req_len    <= '0;
         r_req_stream <= '0;
         r_req_last   <= 1'b0;
      end else begin
         case (r_state)
            SCHED_ARB: begin
               if (w_grant_valid) begin
                  r_req_valid  <= 1'b1;
                  r_req_vaddr  <= r_vaddr[w_grant];
                  r_req_len    <= LEN_W'(w_len);
                  r_req_stream <= w_grant;
                  r_req_last   <= (w_len == r_remaining[w_grant]);
                  r_state      <= SCHED_ISSUE;
               end
            end
            SCHED_ISSUE: begin
               if (bus.req_ready) begin
                  r_req_valid <= 1'b0;
                  r_ptr       <= w_ptr_next;
                  r_state     <= SCHED_ARB;
               end
            end
            default: begin
               r_req_valid <= 1'b0;
               r_state     <= SCHED_ARB;
            end
         endcase
      end
   end

   assign bus.buf_ready  = r_buf_ready;
   assign bus.req_valid  = r_req_valid;
   assign bus.req_vaddr  = r_req_vaddr;
   assign bus.req_len    = r_req_len;
   assign bus.req_stream = r_req_stream;
   assign bus.req_last   = r_req_last;
   assign bus.idle       = (r_state == SCHED_ARB) && (r_full == '0) && (bus.buf_valid == '0);
   assign o_dbg_state    = r_state;

endmodule
